// File: rtl/act_arbiter.sv
// act_arbiter: round-robin arbiter feeding a thresholded activation output register
module act_arbiter #(
    parameter int N          = 4,
    parameter int DW         = 8,
    parameter int THRESH_RST = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_req_valid,
    input  logic [N*DW-1:0]      i_req_data,
    output logic [N-1:0]         o_req_ready,
    input  logic                 i_cfg_we,
    input  logic [DW-1:0]        i_cfg_thresh,
    output logic                 o_res_valid,
    output logic [DW-1:0]        o_res_data,
    output logic [$clog2(N)-1:0] o_res_id,
    input  logic                 i_res_ready,
    output logic                 o_busy,
    output logic [15:0]          o_pass_cnt
);
    localparam int IW = $clog2(N);
    typedef enum logic {RUN, CFG_WAIT} state_t;
    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_rr_ptr, w_gnt, r_res_id;
    logic [DW-1:0] r_thresh, r_pend, w_sample, r_res_data;
    logic [15:0]   r_pass_cnt;
    logic          r_res_valid, w_found, w_free, w_hs, w_accept;
    assign w_free      = !r_res_valid || i_res_ready;
    assign w_hs        = r_res_valid && i_res_ready;
    assign w_accept    = !rst && r_state == RUN && !i_cfg_we && w_free && w_found;
    assign o_req_ready = w_accept ? {{(N-1){1'b0}}, 1'b1} << w_gnt : '0;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_id    = r_res_id;
    assign o_pass_cnt  = r_pass_cnt;
    assign o_busy      = r_state != RUN || r_res_valid;
    // first valid requester at or above rr_ptr, wrapping; k is the search distance, j the matching lane
    always_comb begin
        w_found  = 1'b0;
        w_gnt    = '0;
        w_sample = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                if (!w_found && r_rr_ptr == IW'((j + N - k) % N) && i_req_valid[j]) begin
                    w_found  = 1'b1;
                    w_gnt    = IW'(j);
                    w_sample = i_req_data[j*DW +: DW];
                end
    end
    // a threshold write parks the arbiter until the output slot drains
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == RUN && i_cfg_we)
            w_state_nxt = CFG_WAIT;
        else if (r_state == CFG_WAIT && w_free)
            w_state_nxt = RUN;
    end
    // state, round-robin pointer and threshold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_rr_ptr <= '0;
            r_thresh <= DW'(THRESH_RST);
            r_pend   <= DW'(THRESH_RST);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_rr_ptr <= (w_gnt == IW'(N - 1)) ? '0 : w_gnt + IW'(1);
            if (i_cfg_we)
                r_pend <= i_cfg_thresh;
            if (r_state == CFG_WAIT && w_free)
                r_thresh <= i_cfg_we ? i_cfg_thresh : r_pend;
        end
    end
    // output register: activates on capture, holds while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
        end else if (w_accept) begin
            r_res_valid <= 1'b1;
            r_res_data  <= (w_sample >= r_thresh) ? w_sample : '0;
            r_res_id    <= w_gnt;
        end else if (i_res_ready) begin
            r_res_valid <= 1'b0;
        end
    end
    // count delivered results that survived the threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pass_cnt <= '0;
        else if (w_hs && r_res_data != '0)
            r_pass_cnt <= r_pass_cnt + 16'd1;
    end
endmodule

// File: tb/tb_act_arbiter.sv
// tb_act_arbiter: scoreboard bench for act_arbiter
module tb_act_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_req_valid = '0;
    logic [31:0] i_req_data = '0;
    logic        i_cfg_we = 1'b0;
    logic [7:0]  i_cfg_thresh = '0;
    logic        i_res_ready = 1'b0;
    logic [3:0]  o_req_ready;
    logic        o_res_valid;
    logic [7:0]  o_res_data;
    logic [1:0]  o_res_id;
    logic        o_busy;
    logic [15:0] o_pass_cnt;
    int vecs = 0;
    int miss = 0;
    logic [9:0]  q[$];
    logic [1:0]  m_rr;
    logic        m_st;
    logic [7:0]  m_thresh, m_pend;
    logic [15:0] m_cnt;
    logic [3:0]  m_rdy;
    logic        m_vld;
    logic [9:0]  m_head;

    act_arbiter #(.N(4), .DW(8), .THRESH_RST(10)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
        .i_cfg_we(i_cfg_we), .i_cfg_thresh(i_cfg_thresh),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_id(o_res_id),
        .i_res_ready(i_res_ready), .o_busy(o_busy), .o_pass_cnt(o_pass_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_rr = 2'd0;
        m_st = 1'b0;
        m_thresh = 8'd10;
        m_pend = 8'd10;
        m_cnt = 16'd0;
        q.delete();
    endtask

    // drive one cycle at the falling edge, then predict what the DUT shows and push/pop the scoreboard
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rdy, input logic we, input logic [7:0] th);
        logic       free, found;
        logic [1:0] g;
        logic [7:0] smp;
        @(negedge clk);
        rst = 1'b0;
        i_req_valid = v;
        i_req_data = d;
        i_res_ready = rdy;
        i_cfg_we = we;
        i_cfg_thresh = th;
        #1;
        m_vld = q.size() != 0;
        m_head = m_vld ? q[0] : 10'd0;
        free = !m_vld || rdy;
        found = 1'b0;
        g = 2'd0;
        for (int k = 0; k < 4; k++)
            if (!found && v[m_rr + 2'(k)]) begin
                found = 1'b1;
                g = m_rr + 2'(k);
            end
        m_rdy = (!m_st && !we && free && found) ? 4'b0001 << g : 4'b0000;
        if (m_vld && rdy) begin
            void'(q.pop_front());
            if (m_head[7:0] != 8'd0) m_cnt = m_cnt + 16'd1;
        end
        if (m_rdy != 4'b0000) begin
            smp = 8'(d >> (8 * g));
            q.push_back({g, (smp >= m_thresh) ? smp : 8'd0});
            m_rr = g + 2'd1;
        end
        if (!m_st) begin
            if (we) begin
                m_pend = th;
                m_st = 1'b1;
            end
        end else begin
            if (we) m_pend = th;
            if (free) begin
                m_thresh = m_pend;
                m_st = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        i_req_valid = 4'hF;
        i_req_data = 32'h0B0B0B0B;
        i_res_ready = 1'b1;
        #1;
        vecs++; if (o_req_ready !== 4'b0000) begin miss++; $display("FAIL rst ready: got %b want 0000", o_req_ready); end
        vecs++; if (o_res_valid !== 1'b0) begin miss++; $display("FAIL rst valid: got %b want 0", o_res_valid); end
        vecs++; if (o_res_data !== 8'd0) begin miss++; $display("FAIL rst data: got %0d want 0", o_res_data); end
        vecs++; if (o_res_id !== 2'd0) begin miss++; $display("FAIL rst id: got %0d want 0", o_res_id); end
        vecs++; if (o_pass_cnt !== 16'd0) begin miss++; $display("FAIL rst pass_cnt: got %0d want 0", o_pass_cnt); end
        vecs++; if (o_busy !== 1'b0) begin miss++; $display("FAIL rst busy: got %b want 0", o_busy); end
        model_reset();
    endtask

    task automatic test_threshold();
        logic [7:0] smp [5] = '{8'd9, 8'd10, 8'd255, 8'd0, 8'd0};
        logic [7:0] want [3] = '{8'd0, 8'd10, 8'd255};
        for (int k = 0; k < 5; k++) begin
            step(k < 3 ? 4'b0001 : 4'b0000, {24'd0, smp[k]}, 1'b1, 1'b0, 8'd0);
            vecs++; if (o_req_ready !== m_rdy) begin miss++; $display("FAIL thr ready c%0d: got %b want %b", k, o_req_ready, m_rdy); end
            vecs++; if (o_res_valid !== m_vld || (m_vld && {o_res_id, o_res_data} !== m_head)) begin miss++; $display("FAIL thr result c%0d: got v%b id%0d d%0d want v%b id%0d d%0d", k, o_res_valid, o_res_id, o_res_data, m_vld, m_head[9:8], m_head[7:0]); end
            if (k == 0) begin vecs++; if (o_req_ready !== 4'b0001) begin miss++; $display("FAIL thr first_grant: got %b want 0001", o_req_ready); end end
            if (k >= 1 && k <= 3) begin vecs++; if (o_res_data !== want[k-1]) begin miss++; $display("FAIL thr value c%0d: got %0d want %0d", k, o_res_data, want[k-1]); end end
        end
        vecs++; if (o_pass_cnt !== 16'd2) begin miss++; $display("FAIL thr pass_cnt: got %0d want 2", o_pass_cnt); end
    endtask

    task automatic test_round_robin();
        logic [31:0] d = {8'd40, 8'd30, 8'd20, 8'd11};
        step(4'b1000, d, 1'b1, 1'b0, 8'd0);
        vecs++; if (o_req_ready !== m_rdy) begin miss++; $display("FAIL rr prep ready: got %b want %b", o_req_ready, m_rdy); end
        for (int k = 0; k < 9; k++) begin
            step(k < 8 ? 4'b1111 : 4'b0000, d, 1'b1, 1'b0, 8'd0);
            vecs++; if (o_req_ready !== m_rdy) begin miss++; $display("FAIL rr ready c%0d: got %b want %b", k, o_req_ready, m_rdy); end
            vecs++; if (o_res_valid !== m_vld || (m_vld && {o_res_id, o_res_data} !== m_head)) begin miss++; $display("FAIL rr result c%0d: got v%b id%0d d%0d want v%b id%0d d%0d", k, o_res_valid, o_res_id, o_res_data, m_vld, m_head[9:8], m_head[7:0]); end
            if (k < 8) begin vecs++; if (o_req_ready !== 4'(1 << (k % 4))) begin miss++; $display("FAIL rr onehot c%0d: got %b want %b", k, o_req_ready, 4'(1 << (k % 4))); end end
            if (k >= 1) begin vecs++; if (o_res_id !== 2'((k - 1) % 4)) begin miss++; $display("FAIL rr id c%0d: got %0d want %0d", k, o_res_id, (k - 1) % 4); end end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d = {16'd0, 8'd60, 8'd50};
        for (int k = 0; k < 9; k++) begin
            step(k < 7 ? 4'b0011 : 4'b0000, d, (k == 0 || k >= 6) ? 1'b1 : 1'b0, 1'b0, 8'd0);
            vecs++; if (o_req_ready !== m_rdy) begin miss++; $display("FAIL bp ready c%0d: got %b want %b", k, o_req_ready, m_rdy); end
            vecs++; if (o_res_valid !== m_vld || (m_vld && {o_res_id, o_res_data} !== m_head)) begin miss++; $display("FAIL bp result c%0d: got v%b id%0d d%0d want v%b id%0d d%0d", k, o_res_valid, o_res_id, o_res_data, m_vld, m_head[9:8], m_head[7:0]); end
            if (k >= 1 && k <= 6) begin
                vecs++; if (o_res_valid !== 1'b1 || o_res_data !== 8'd50 || o_res_id !== 2'd0) begin miss++; $display("FAIL bp hold c%0d: got v%b id%0d d%0d want v1 id0 d50", k, o_res_valid, o_res_id, o_res_data); end
                vecs++; if (o_req_ready !== (k == 6 ? 4'b0010 : 4'b0000)) begin miss++; $display("FAIL bp stall_ready c%0d: got %b", k, o_req_ready); end
            end
            if (k == 7) begin vecs++; if (o_res_data !== 8'd60 || o_res_id !== 2'd1) begin miss++; $display("FAIL bp second: got id%0d d%0d want id1 d60", o_res_id, o_res_data); end end
            if (k == 8) begin vecs++; if (o_res_valid !== 1'b0) begin miss++; $display("FAIL bp drained: got v%b want v0", o_res_valid); end end
        end
    endtask

    task automatic test_cfg_update();
        logic [3:0] v [8]   = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic       rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       we [8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] th [8]  = '{8'd0, 8'd30, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       bsy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            step(v[k], 32'd40, rdy[k], we[k], th[k]);
            vecs++; if (o_req_ready !== m_rdy) begin miss++; $display("FAIL cfg ready c%0d: got %b want %b", k, o_req_ready, m_rdy); end
            vecs++; if (o_res_valid !== m_vld || (m_vld && {o_res_id, o_res_data} !== m_head)) begin miss++; $display("FAIL cfg result c%0d: got v%b id%0d d%0d want v%b id%0d d%0d", k, o_res_valid, o_res_id, o_res_data, m_vld, m_head[9:8], m_head[7:0]); end
            vecs++; if (o_busy !== bsy[k]) begin miss++; $display("FAIL cfg busy c%0d: got %b want %b", k, o_busy, bsy[k]); end
            if (k >= 2 && k <= 4) begin vecs++; if (o_req_ready !== 4'b0000) begin miss++; $display("FAIL cfg wait_ready c%0d: got %b want 0000", k, o_req_ready); end end
            if (k == 4) begin vecs++; if (o_res_data !== 8'd40) begin miss++; $display("FAIL cfg old_thresh: got %0d want 40", o_res_data); end end
            if (k == 6) begin vecs++; if (o_res_valid !== 1'b1 || o_res_data !== 8'd0) begin miss++; $display("FAIL cfg new_thresh: got v%b d%0d want v1 d0", o_res_valid, o_res_data); end end
        end
    endtask

    task automatic test_reset_mid_stall();
        step(4'b0010, {16'd0, 8'd77, 8'd0}, 1'b1, 1'b0, 8'd0);
        vecs++; if (o_req_ready !== 4'b0010) begin miss++; $display("FAIL mrst grant: got %b want 0010", o_req_ready); end
        step(4'b0010, {16'd0, 8'd77, 8'd0}, 1'b0, 1'b0, 8'd0);
        vecs++; if (o_res_valid !== 1'b1 || o_res_data !== 8'd77 || o_res_id !== 2'd1) begin miss++; $display("FAIL mrst stalled: got v%b id%0d d%0d want v1 id1 d77", o_res_valid, o_res_id, o_res_data); end
        #1;
        rst = 1'b1;
        #1;
        vecs++; if (o_res_valid !== 1'b0 || o_res_data !== 8'd0 || o_res_id !== 2'd0) begin miss++; $display("FAIL mrst outputs: got v%b id%0d d%0d want v0 id0 d0", o_res_valid, o_res_id, o_res_data); end
        vecs++; if (o_req_ready !== 4'b0000) begin miss++; $display("FAIL mrst ready: got %b want 0000", o_req_ready); end
        vecs++; if (o_busy !== 1'b0 || o_pass_cnt !== 16'd0) begin miss++; $display("FAIL mrst busy_cnt: got b%b c%0d want b0 c0", o_busy, o_pass_cnt); end
        model_reset();
        step(4'b1111, {8'd40, 8'd30, 8'd20, 8'd20}, 1'b1, 1'b0, 8'd0);
        vecs++; if (o_req_ready !== 4'b0001 || m_rdy !== 4'b0001) begin miss++; $display("FAIL mrst first_grant: got %b want 0001", o_req_ready); end
        step(4'b0000, 32'd0, 1'b1, 1'b0, 8'd0);
        vecs++; if (o_res_valid !== 1'b1 || o_res_data !== 8'd20 || o_res_id !== 2'd0) begin miss++; $display("FAIL mrst thresh_restored: got v%b id%0d d%0d want v1 id0 d20", o_res_valid, o_res_id, o_res_data); end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            step(4'b0001, 32'd255, 1'b1, 1'b0, 8'd0);
            guard++;
        end
        vecs++; if (guard >= 70000) begin miss++; $display("FAIL wrap preload: got cnt %0d want 65535 within budget", m_cnt); end
        step(4'b0000, 32'd0, 1'b1, 1'b0, 8'd0);
        vecs++; if (o_pass_cnt !== 16'hFFFF) begin miss++; $display("FAIL wrap full: got %h want ffff", o_pass_cnt); end
        vecs++; if (o_res_valid !== 1'b1 || o_res_data !== 8'd255) begin miss++; $display("FAIL wrap last: got v%b d%0d want v1 d255", o_res_valid, o_res_data); end
        step(4'b0000, 32'd0, 1'b1, 1'b0, 8'd0);
        vecs++; if (o_pass_cnt !== 16'h0000) begin miss++; $display("FAIL wrap zero: got %h want 0000", o_pass_cnt); end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_round_robin();
        test_backpressure();
        test_cfg_update();
        test_reset_mid_stall();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/act_arbiter.md
ACT_ARBITER -- requirements
Module: act_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the activation datapath.
REQ-002 Parameter DW, default 8: sample width in bits.
REQ-003 Parameter THRESH_RST, default 10: threshold value loaded at reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  N  per-requester sample valid.
REQ-007 req_data  input  N*DW  packed samples; requester i occupies bits [i*DW +: DW].
REQ-008 req_ready  output  N  per-requester accept; one-hot or zero.
REQ-009 cfg_we  input  1  one-cycle threshold write strobe.
REQ-010 cfg_thresh  input  DW  new threshold value, sampled when cfg_we=1.
REQ-011 res_valid  output  1  result valid.
REQ-012 res_data  output  DW  activated result.
REQ-013 res_id  output  clog2(N)  index of the requester that produced res_data.
REQ-014 res_ready  input  1  downstream accept.
REQ-015 busy  output  1  high whenever state is not RUN or res_valid=1.
REQ-016 pass_cnt  output  16  count of results delivered with a nonzero value (res_data != 0).

Function
REQ-017 State machine states: RUN, CFG_WAIT; there are no other states.
REQ-018 In RUN, a transfer is accepted when req_valid[g] & req_ready[g]=1, and req_ready[g]=1 only for the granted index g.
REQ-019 g is the first index with req_valid set, searching upward from rr_ptr modulo N.
REQ-020 A grant is issued only if the output slot is free: res_valid=0, or res_ready=1 in the same cycle.
REQ-021 On acceptance, rr_ptr is set to (g+1) mod N; otherwise rr_ptr holds.
REQ-022 Activation is unsigned: if sample >= thresh then res_data = sample, else res_data = 0.
REQ-023 The result is registered: res_valid, res_data and res_id appear on the cycle after acceptance (1-cycle latency).
REQ-024 Throughput is one sample per cycle while res_ready=1.
REQ-025 res_valid, res_data and res_id are held stable while res_valid=1 and res_ready=0.
REQ-026 res_valid clears after a handshake unless a new sample is accepted in the same cycle.
REQ-027 pass_cnt increments on each res_valid & res_ready with res_data != 0, and wraps from 0xFFFF to 0.
REQ-028 On cfg_we in RUN, cfg_thresh is latched into a pending register, no grant is issued that cycle, and the state goes to CFG_WAIT.
REQ-029 In CFG_WAIT, req_ready=0; once res_valid=0, or a res_valid & res_ready handshake completes, the pending value is copied to thresh and the state returns to RUN on the next cycle.
REQ-030 A cfg_we received in CFG_WAIT overwrites the pending value; the last write wins.
REQ-031 A sample already in the output register keeps the threshold that was in force when it was accepted.
REQ-032 A requester that drops req_valid without a handshake loses its grant, and the arbitration for that cycle picks the next valid requester.

Reset
REQ-033 While rst=1: req_ready=0, res_valid=0, res_data=0, res_id=0, pass_cnt=0, rr_ptr=0, thresh=THRESH_RST, pending=THRESH_RST, state=RUN.
REQ-034 Reset mid-operation discards any in-flight result and any pending threshold; no partial handshake completes.
REQ-035 The first grant can occur in the first clock cycle after rst deasserts.

Verification
REQ-036 Threshold boundary: with thresh=10 and res_ready=1, requester 0 sends 9, 10, 255 -> results 0, 10, 255; pass_cnt=2.
REQ-037 Round-robin fairness: all 4 requesters valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0,1; each req_ready is high exactly once per 4 cycles.
REQ-038 Backpressure: res_ready=0 for 5 cycles with 2 requesters valid -> res_data and res_id are held, req_ready=0 for the full stall, no sample is lost or duplicated after release.
REQ-039 Threshold update: write cfg_thresh=50 while a result of 40 is stalled -> 40 is delivered unchanged, state=CFG_WAIT until the handshake, and the next sample of 40 yields 0.
REQ-040 Reset mid-stall: assert rst while res_valid=1 -> all outputs return to their reset values immediately, thresh=10, and the next grant goes to requester 0 first.
REQ-041 Counter wrap: preload traffic until pass_cnt=0xFFFF, then one nonzero result -> pass_cnt=0.
